// File: rtl/ctrl_pkg.sv
// Shared encodings, opcodes and the decoded control bundle for the RV32I decode stage.
package ctrl_pkg;

   localparam int ALUOP_BASE_W = 5;

   localparam logic [4:0] ALU_NOP   = 5'd0;
   localparam logic [4:0] ALU_LUI   = 5'd1;
   localparam logic [4:0] ALU_AUIPC = 5'd2;
   localparam logic [4:0] ALU_ADD   = 5'd3;
   localparam logic [4:0] ALU_SUB   = 5'd4;
   localparam logic [4:0] ALU_BNE   = 5'd5;
   localparam logic [4:0] ALU_BLT   = 5'd6;
   localparam logic [4:0] ALU_BGE   = 5'd7;
   localparam logic [4:0] ALU_BLTU  = 5'd8;
   localparam logic [4:0] ALU_BGEU  = 5'd9;
   localparam logic [4:0] ALU_SLT   = 5'd10;
   localparam logic [4:0] ALU_SLTU  = 5'd11;
   localparam logic [4:0] ALU_XOR   = 5'd12;
   localparam logic [4:0] ALU_OR    = 5'd13;
   localparam logic [4:0] ALU_AND   = 5'd14;
   localparam logic [4:0] ALU_SLL   = 5'd15;
   localparam logic [4:0] ALU_SRL   = 5'd16;
   localparam logic [4:0] ALU_SRA   = 5'd17;
   localparam logic [4:0] ALU_MUL   = 5'd18;

   localparam logic [5:0] EXT_NONE  = 6'b000000;
   localparam logic [5:0] EXT_SHAMT = 6'b100000;
   localparam logic [5:0] EXT_I     = 6'b010000;
   localparam logic [5:0] EXT_S     = 6'b001000;
   localparam logic [5:0] EXT_B     = 6'b000100;
   localparam logic [5:0] EXT_U     = 6'b000010;
   localparam logic [5:0] EXT_J     = 6'b000001;

   localparam logic [2:0] WD_ALU   = 3'd0;
   localparam logic [2:0] WD_PC    = 3'd1;
   localparam logic [2:0] WD_WORD  = 3'd2;
   localparam logic [2:0] WD_HALF  = 3'd3;
   localparam logic [2:0] WD_BYTE  = 3'd4;
   localparam logic [2:0] WD_HALFU = 3'd5;
   localparam logic [2:0] WD_BYTEU = 3'd6;

   localparam logic [2:0] DM_WORD  = 3'd0;
   localparam logic [2:0] DM_HALF  = 3'd1;
   localparam logic [2:0] DM_HALFU = 3'd2;
   localparam logic [2:0] DM_BYTE  = 3'd3;
   localparam logic [2:0] DM_BYTEU = 3'd4;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   typedef struct packed {
      logic       regwrite;
      logic       memwrite;
      logic       memread;
      logic       alusrc;
      logic [5:0] extop;
      logic [4:0] aluop;
      logic [2:0] wdsel;
      logic [2:0] dmtype;
      logic       branch;
      logic       jal;
      logic       jalr;
      logic       illegal;
   } ctrl_bundle;

   // Shared by R-type and I-type arithmetic; shifts are refined by the caller.
   function automatic logic [4:0] alu_of_funct3(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic ctrl_bundle illegal_bundle();
      ctrl_bundle b;
      b = '0;
      b.illegal = 1'b1;
      return b;
   endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational RV32I decoder; RV32M_EN adds the M-extension R-type ops.
import ctrl_pkg::*;

module ctrl_decode_comb (
   input  logic [31:0] instr,
   output ctrl_bundle  ctrl,
   output logic        uses_rs1,
   output logic        uses_rs2,
   output logic        is_load,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   ctrl_bundle c;
   logic       ill, u1, u2, ld;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];

   always_comb begin
      c   = '0;
      ill = 1'b0;
      u1  = 1'b0;
      u2  = 1'b0;
      ld  = 1'b0;
      case (opcode)
         OP_R: begin
            c.regwrite = 1'b1;
            c.wdsel    = WD_ALU;
            u1 = 1'b1;
            u2 = 1'b1;
            case (funct7)
               7'b0000000: c.aluop = alu_of_funct3(funct3);
               7'b0100000: begin
                  if (funct3 == 3'b000)      c.aluop = ALU_SUB;
                  else if (funct3 == 3'b101) c.aluop = ALU_SRA;
                  else                       ill = 1'b1;
               end
`ifdef RV32M_EN
               7'b0000001: c.aluop = ALU_MUL + {2'b00, funct3};
`else
               7'b0000001: ill = 1'b1;
`endif
               default:    ill = 1'b1;
            endcase
         end
         OP_I: begin
            c.regwrite = 1'b1;
            c.alusrc   = 1'b1;
            c.extop    = EXT_I;
            u1 = 1'b1;
            case (funct3)
               3'b001: begin
                  c.extop = EXT_SHAMT;
                  if (funct7 == 7'b0000000) c.aluop = ALU_SLL;
                  else                      ill = 1'b1;
               end
               3'b101: begin
                  c.extop = EXT_SHAMT;
                  if (funct7 == 7'b0000000)      c.aluop = ALU_SRL;
                  else if (funct7 == 7'b0100000) c.aluop = ALU_SRA;
                  else                           ill = 1'b1;
               end
               default: c.aluop = alu_of_funct3(funct3);
            endcase
         end
         OP_LOAD: begin
            c.regwrite = 1'b1;
            c.memread  = 1'b1;
            c.alusrc   = 1'b1;
            c.extop    = EXT_I;
            c.aluop    = ALU_ADD;
            u1 = 1'b1;
            ld = 1'b1;
            case (funct3)
               3'b000:  begin c.wdsel = WD_BYTE;  c.dmtype = DM_BYTE;  end
               3'b001:  begin c.wdsel = WD_HALF;  c.dmtype = DM_HALF;  end
               3'b010:  begin c.wdsel = WD_WORD;  c.dmtype = DM_WORD;  end
               3'b100:  begin c.wdsel = WD_BYTEU; c.dmtype = DM_BYTEU; end
               3'b101:  begin c.wdsel = WD_HALFU; c.dmtype = DM_HALFU; end
               default: ill = 1'b1;
            endcase
         end
         OP_S: begin
            c.memwrite = 1'b1;
            c.alusrc   = 1'b1;
            c.extop    = EXT_S;
            c.aluop    = ALU_ADD;
            u1 = 1'b1;
            u2 = 1'b1;
            case (funct3)
               3'b000:  c.dmtype = DM_BYTE;
               3'b001:  c.dmtype = DM_HALF;
               3'b010:  c.dmtype = DM_WORD;
               default: ill = 1'b1;
            endcase
         end
         OP_B: begin
            c.branch = 1'b1;
            c.extop  = EXT_B;
            u1 = 1'b1;
            u2 = 1'b1;
            case (funct3)
               3'b000:  c.aluop = ALU_SUB;
               3'b001:  c.aluop = ALU_BNE;
               3'b100:  c.aluop = ALU_BLT;
               3'b101:  c.aluop = ALU_BGE;
               3'b110:  c.aluop = ALU_BLTU;
               3'b111:  c.aluop = ALU_BGEU;
               default: ill = 1'b1;
            endcase
         end
         OP_LUI: begin
            c.regwrite = 1'b1;
            c.alusrc   = 1'b1;
            c.extop    = EXT_U;
            c.aluop    = ALU_LUI;
         end
         OP_AUIPC: begin
            c.regwrite = 1'b1;
            c.alusrc   = 1'b1;
            c.extop    = EXT_U;
            c.aluop    = ALU_AUIPC;
         end
         OP_JAL: begin
            c.regwrite = 1'b1;
            c.jal      = 1'b1;
            c.extop    = EXT_J;
            c.wdsel    = WD_PC;
            c.aluop    = ALU_NOP;
         end
         OP_JALR: begin
            c.regwrite = 1'b1;
            c.jalr     = 1'b1;
            c.alusrc   = 1'b1;
            c.extop    = EXT_I;
            c.wdsel    = WD_PC;
            c.aluop    = ALU_ADD;
            u1 = 1'b1;
            if (funct3 != 3'b000) ill = 1'b1;
         end
         default: ill = 1'b1;
      endcase

      // Illegal words must not touch state or create a load-use hazard.
      if (ill) begin
         c  = illegal_bundle();
         u1 = 1'b0;
         u2 = 1'b0;
         ld = 1'b0;
      end
      if (rd == 5'd0) c.regwrite = 1'b0;
   end

   assign ctrl     = c;
   assign uses_rs1 = u1;
   assign uses_rs2 = u2;
   assign is_load  = ld;

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered ID/EX decode stage: handshake, flush and load-use interlock.
// RV32M_EN (see ctrl_decode_comb) enables the M-extension decodes.
//
// state | meaning
// FREE  | lu_cnt == 0, no load result outstanding
// ARMED | lu_cnt >  0, readers of pending_rd are held at the input
import ctrl_pkg::*;

module ctrl_decode_stage #(
   parameter int XLEN       = 32,
   parameter int ALUOP_W    = 5,
   parameter int LU_BUBBLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_instr,
   input  logic [XLEN-1:0]    in_pc,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_regwrite,
   output logic               out_memwrite,
   output logic               out_memread,
   output logic               out_alusrc,
   output logic [5:0]         out_extop,
   output logic [ALUOP_W-1:0] out_aluop,
   output logic [2:0]         out_wdsel,
   output logic [2:0]         out_dmtype,
   output logic               out_branch,
   output logic               out_jal,
   output logic               out_jalr,
   output logic [4:0]         out_rs1,
   output logic [4:0]         out_rs2,
   output logic [4:0]         out_rd,
   output logic [XLEN-1:0]    out_pc,
   output logic               out_illegal
);

   localparam logic [0:0] LU_FREE  = 1'b0;
   localparam logic [0:0] LU_ARMED = 1'b1;
   localparam logic [1:0] LU_INIT  = 2'(LU_BUBBLES);

   ctrl_bundle dec;
   logic       dec_u1, dec_u2, dec_ld;
   logic [4:0] dec_rs1, dec_rs2, dec_rd;

   logic [1:0] lu_cnt;
   logic [4:0] pending_rd;
   logic [0:0] lu_state;
   logic       lu_hold, accept, load_arm, downstream_free;

   ctrl_decode_comb u_dec (
      .instr    (in_instr),
      .ctrl     (dec),
      .uses_rs1 (dec_u1),
      .uses_rs2 (dec_u2),
      .is_load  (dec_ld),
      .rs1      (dec_rs1),
      .rs2      (dec_rs2),
      .rd       (dec_rd)
   );

   assign lu_state        = (lu_cnt != 2'd0) ? LU_ARMED : LU_FREE;
   assign lu_hold         = (lu_state == LU_ARMED) && in_valid &&
                            ((dec_u1 && dec_rs1 == pending_rd) ||
                             (dec_u2 && dec_rs2 == pending_rd));
   assign downstream_free = !out_valid || out_ready;
   assign in_ready        = !flush && downstream_free && !lu_hold;
   assign accept          = in_valid && in_ready;
   assign load_arm        = accept && dec_ld && (dec_rd != 5'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_regwrite <= 1'b0;
         out_memwrite <= 1'b0;
         out_memread  <= 1'b0;
         out_alusrc   <= 1'b0;
         out_extop    <= '0;
         out_aluop    <= '0;
         out_wdsel    <= '0;
         out_dmtype   <= '0;
         out_branch   <= 1'b0;
         out_jal      <= 1'b0;
         out_jalr     <= 1'b0;
         out_rs1      <= '0;
         out_rs2      <= '0;
         out_rd       <= '0;
         out_pc       <= '0;
         out_illegal  <= 1'b0;
         lu_cnt       <= 2'd0;
         pending_rd   <= 5'd0;
      end else if (flush) begin
         out_valid <= 1'b0;
         lu_cnt    <= 2'd0;
      end else begin
         if (accept) begin
            out_valid    <= 1'b1;
            out_regwrite <= dec.regwrite;
            out_memwrite <= dec.memwrite;
            out_memread  <= dec.memread;
            out_alusrc   <= dec.alusrc;
            out_extop    <= dec.extop;
            out_aluop    <= ALUOP_W'(dec.aluop);
            out_wdsel    <= dec.wdsel;
            out_dmtype   <= dec.dmtype;
            out_branch   <= dec.branch;
            out_jal      <= dec.jal;
            out_jalr     <= dec.jalr;
            out_rs1      <= dec_rs1;
            out_rs2      <= dec_rs2;
            out_rd       <= dec_rd;
            out_pc       <= in_pc;
            out_illegal  <= dec.illegal;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         // The bubble only counts down while the load is actually moving on.
         if (load_arm) begin
            pending_rd <= dec_rd;
            lu_cnt     <= LU_INIT;
         end else if (lu_state == LU_ARMED && downstream_free && !(accept && dec_ld)) begin
            lu_cnt <= lu_cnt - 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage; expectations follow RV32M_EN when defined.
module tb_ctrl_decode_stage;

  typedef struct packed {
    logic [4:0]  aluop;
    logic        rw, mw, mr, as;
    logic [5:0]  extop;
    logic [2:0]  wdsel;
    logic [2:0]  dmtype;
    logic        br, jal, jalr;
    logic        ill;
    logic [4:0]  rd;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_valid2, flush, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid, out_regwrite, out_memwrite, out_memread, out_alusrc;
  logic [5:0]  out_extop;
  logic [4:0]  out_aluop;
  logic [2:0]  out_wdsel, out_dmtype;
  logic        out_branch, out_jal, out_jalr, out_illegal;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_pc;

  logic        d2_in_ready, d2_out_valid, d2_regwrite, d2_memwrite, d2_memread, d2_alusrc;
  logic [5:0]  d2_extop;
  logic [4:0]  d2_aluop;
  logic [2:0]  d2_wdsel, d2_dmtype;
  logic        d2_branch, d2_jal, d2_jalr, d2_illegal;
  logic [4:0]  d2_rs1, d2_rs2, d2_rd;
  logic [31:0] d2_pc;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ctrl_decode_stage #(.XLEN(32), .ALUOP_W(5), .LU_BUBBLES(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_regwrite(out_regwrite), .out_memwrite(out_memwrite),
    .out_memread(out_memread), .out_alusrc(out_alusrc),
    .out_extop(out_extop), .out_aluop(out_aluop), .out_wdsel(out_wdsel),
    .out_dmtype(out_dmtype), .out_branch(out_branch), .out_jal(out_jal),
    .out_jalr(out_jalr), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  ctrl_decode_stage #(.XLEN(32), .ALUOP_W(5), .LU_BUBBLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(d2_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(d2_out_valid), .out_ready(out_ready),
    .out_regwrite(d2_regwrite), .out_memwrite(d2_memwrite),
    .out_memread(d2_memread), .out_alusrc(d2_alusrc),
    .out_extop(d2_extop), .out_aluop(d2_aluop), .out_wdsel(d2_wdsel),
    .out_dmtype(d2_dmtype), .out_branch(d2_branch), .out_jal(d2_jal),
    .out_jalr(d2_jalr), .out_rs1(d2_rs1), .out_rs2(d2_rs2),
    .out_rd(d2_rd), .out_pc(d2_pc), .out_illegal(d2_illegal)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] aluop, input logic [3:0] ctl,
                              input logic [5:0] ext, input logic [2:0] wd,
                              input logic [2:0] dm, input logic [2:0] cf,
                              input logic ill, input logic [4:0] rd);
    return {aluop, ctl, ext, wd, dm, cf, ill, rd, 32'h0};
  endfunction

  // Monitor: every consumed ID/EX packet is compared against the oldest expectation.
  initial begin
    exp_t a, e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        a = {out_aluop, out_regwrite, out_memwrite, out_memread, out_alusrc, out_extop,
             out_wdsel, out_dmtype, out_branch, out_jal, out_jalr, out_illegal, out_rd, out_pc};
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got packet %0h expected none", a);
        end else begin
          e = sb.pop_front();
          chk($sformatf("sb_pc%0h", e.pc), 64'(a), 64'(e));
        end
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e,
                      input bit push, output int stalls, output logic ov);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    e.pc     = pc;
    stalls   = 0;
    ov       = 1'bx;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        ov = out_valid;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        break;
      end
      stalls++;
      if (stalls > 20) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: pc %0h never accepted, required acceptance", pc);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  localparam int N = 20;
  logic [31:0] t_instr [N];
  exp_t        t_exp   [N];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int   st;
    logic ov;

    t_instr[0]  = 32'h002081B3; t_exp[0]  = mk(5'd3,  4'b1000, 6'b000000, 3'd0, 3'd0, 3'b000, 1'b0, 5'd3);
    t_instr[1]  = 32'h40208233; t_exp[1]  = mk(5'd4,  4'b1000, 6'b000000, 3'd0, 3'd0, 3'b000, 1'b0, 5'd4);
    t_instr[2]  = 32'h0020B3B3; t_exp[2]  = mk(5'd11, 4'b1000, 6'b000000, 3'd0, 3'd0, 3'b000, 1'b0, 5'd7);
    t_instr[3]  = 32'h4030D413; t_exp[3]  = mk(5'd17, 4'b1001, 6'b100000, 3'd0, 3'd0, 3'b000, 1'b0, 5'd8);
    t_instr[4]  = 32'h0030D413; t_exp[4]  = mk(5'd16, 4'b1001, 6'b100000, 3'd0, 3'd0, 3'b000, 1'b0, 5'd8);
    t_instr[5]  = 32'h0000A283; t_exp[5]  = mk(5'd3,  4'b1011, 6'b010000, 3'd2, 3'd0, 3'b000, 1'b0, 5'd5);
    t_instr[6]  = 32'h00100093; t_exp[6]  = mk(5'd3,  4'b1001, 6'b010000, 3'd0, 3'd0, 3'b000, 1'b0, 5'd1);
    t_instr[7]  = 32'h0040C483; t_exp[7]  = mk(5'd3,  4'b1011, 6'b010000, 3'd6, 3'd4, 3'b000, 1'b0, 5'd9);
    t_instr[8]  = 32'h00209423; t_exp[8]  = mk(5'd3,  4'b0101, 6'b001000, 3'd0, 3'd1, 3'b000, 1'b0, 5'd8);
    t_instr[9]  = 32'h00209063; t_exp[9]  = mk(5'd5,  4'b0000, 6'b000100, 3'd0, 3'd0, 3'b100, 1'b0, 5'd0);
    t_instr[10] = 32'h12345537; t_exp[10] = mk(5'd1,  4'b1001, 6'b000010, 3'd0, 3'd0, 3'b000, 1'b0, 5'd10);
    t_instr[11] = 32'h000000EF; t_exp[11] = mk(5'd0,  4'b1000, 6'b000001, 3'd1, 3'd0, 3'b010, 1'b0, 5'd1);
    t_instr[12] = 32'h000100E7; t_exp[12] = mk(5'd3,  4'b1001, 6'b010000, 3'd1, 3'd0, 3'b001, 1'b0, 5'd1);
    t_instr[13] = 32'h00000013; t_exp[13] = mk(5'd3,  4'b0001, 6'b010000, 3'd0, 3'd0, 3'b000, 1'b0, 5'd0);
    t_instr[14] = 32'h0000007F; t_exp[14] = mk(5'd0,  4'b0000, 6'b000000, 3'd0, 3'd0, 3'b000, 1'b1, 5'd0);
`ifdef RV32M_EN
    t_instr[15] = 32'h022081B3; t_exp[15] = mk(5'd18, 4'b1000, 6'b000000, 3'd0, 3'd0, 3'b000, 1'b0, 5'd3);
`else
    t_instr[15] = 32'h022081B3; t_exp[15] = mk(5'd0,  4'b0000, 6'b000000, 3'd0, 3'd0, 3'b000, 1'b1, 5'd3);
`endif
    t_instr[16] = 32'h202081B3; t_exp[16] = mk(5'd0,  4'b0000, 6'b000000, 3'd0, 3'd0, 3'b000, 1'b1, 5'd3);
    t_instr[17] = 32'h00208063; t_exp[17] = mk(5'd4,  4'b0000, 6'b000100, 3'd0, 3'd0, 3'b100, 1'b0, 5'd0);
    t_instr[18] = 32'h00009583; t_exp[18] = mk(5'd3,  4'b1011, 6'b010000, 3'd3, 3'd1, 3'b000, 1'b0, 5'd11);
    t_instr[19] = 32'h0000B583; t_exp[19] = mk(5'd0,  4'b0000, 6'b000000, 3'd0, 3'd0, 3'b000, 1'b1, 5'd11);

    rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; flush = 1'b1;
    out_ready = 1'b1; in_instr = 32'h002081B3; in_pc = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b0;
    in_instr = 32'h0;
    in_pc = 32'h0;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_aluop", 64'(out_aluop), 64'd0);
    chk("rst_regwrite", 64'(out_regwrite), 64'd0);
    chk("rst_extop", 64'(out_extop), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_d2_valid", 64'(d2_out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Back-to-back decodes with EX always ready: nothing here should stall.
    for (int i = 0; i < N; i++) begin
      send(t_instr[i], 32'h100 + 32'(i) * 4, t_exp[i], 1'b1, st, ov);
      chk($sformatf("table_stall%0d", i), 64'(st), 64'd0);
    end

    // Load followed by a dependent add: one bubble.
    send(32'h0000A283, 32'h200, mk(5'd3, 4'b1011, 6'b010000, 3'd2, 3'd0, 3'b000, 1'b0, 5'd5), 1'b1, st, ov);
    send(32'h00528333, 32'h204, mk(5'd3, 4'b1000, 6'b000000, 3'd0, 3'd0, 3'b000, 1'b0, 5'd6), 1'b1, st, ov);
    chk("lu1_stalls", 64'(st), 64'd1);
    chk("lu1_bubble_valid", 64'(ov), 64'd0);
    @(negedge clk);
    chk("lu1_latency_valid", 64'(out_valid), 64'd1);
    chk("lu1_latency_pc", 64'(out_pc), 64'h204);
    @(posedge clk);
    #1;

    // Same pair on the two-bubble instance, with the first instance idle.
    in_valid2 = 1'b1;
    in_instr  = 32'h0000A283;
    st = 0;
    while (!d2_in_ready && st < 10) begin
      @(negedge clk);
      st++;
    end
    @(posedge clk);
    #1;
    in_instr = 32'h00528333;
    st = 0;
    forever begin
      @(negedge clk);
      if (d2_in_ready || st > 10) break;
      st++;
    end
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    chk("lu2_stalls", 64'(st), 64'd2);
    @(negedge clk);
    chk("lu2_out_rd", 64'(d2_rd), 64'd6);
    @(posedge clk);
    #1;

    // Held load flushed while EX is stalled; interlock must be cleared too.
    out_ready = 1'b0;
    send(32'h0000A283, 32'h300, mk(5'd3, 4'b1011, 6'b010000, 3'd2, 3'd0, 3'b000, 1'b0, 5'd5), 1'b0, st, ov);
    @(negedge clk);
    chk("hold_in_ready", 64'(in_ready), 64'd0);
    chk("hold_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00528333;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    out_ready = 1'b1;
    send(32'h00528333, 32'h304, mk(5'd3, 4'b1000, 6'b000000, 3'd0, 3'd0, 3'b000, 1'b0, 5'd6), 1'b1, st, ov);
    chk("flush_clears_lu", 64'(st), 64'd0);
    chk("flush_out_valid", 64'(ov), 64'd0);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
